crc_lfsr_serializer: RTL and testbench

CRC_LFSR_SERIALIZER -- requirements
Module: crc_lfsr_serializer

---
 rtl/crc_pkg.sv | 19 +
 rtl/crc_bit_counter.sv | 38 +++
 rtl/crc_lfsr_serializer.sv | 108 ++++++++++
 tb/tb_crc_lfsr_serializer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared constants and state encoding for the serial CRC LFSR serializer.
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam logic [7:0]  DEFAULT_SEED  = 8'hD8;
  localparam logic [7:0]  DEFAULT_POLY  = 8'b0100_0100;

  // Counter width large enough to reach WIDTH-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/crc_bit_counter.sv
// Counts emitted CRC bits; last flags the final bit of a frame.
module crc_bit_counter
  import crc_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic last
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [CW-1:0] count_q, count_d;

  // Clear wins over increment so the final bit returns the count to zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/crc_lfsr_serializer.sv
// Serial CRC: absorbs message bits into an LFSR, then shifts the CRC out LSB first.
module crc_lfsr_serializer
  import crc_pkg::*;
#(
  parameter int unsigned      WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED,
  parameter logic [WIDTH-1:0] POLY  = DEFAULT_POLY
) (
  input  logic clk,
  input  logic reset_n,
  input  logic data_in,
  input  logic active,
  output logic crc_out,
  output logic valid,
  output logic busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic             crc_out_q, crc_out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             fb;
  logic [WIDTH-1:0] absorbed;
  logic             cnt_en, cnt_clr, cnt_last;

  crc_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .last    (cnt_last)
  );

  // One Galois-style absorb step of the current message bit.
  always_comb begin
    fb       = data_in ^ lfsr_q[0];
    absorbed = {fb, lfsr_q[WIDTH-1:1] ^ (POLY[WIDTH-2:0] & {(WIDTH-1){fb}})};
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    crc_out_d = 1'b0;
    valid_d   = 1'b0;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (active) begin
          lfsr_d  = absorbed;
          state_d = ST_CALC;
        end else begin
          lfsr_d = SEED;
        end
      end
      ST_CALC: begin
        if (active) begin
          lfsr_d = absorbed;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Message inputs are ignored here so the finished CRC stays intact.
        crc_out_d = lfsr_q[0];
        valid_d   = 1'b1;
        lfsr_d    = {1'b0, lfsr_q[WIDTH-1:1]};
        cnt_en    = 1'b1;
        if (cnt_last) begin
          state_d = ST_IDLE;
          lfsr_d  = SEED;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        lfsr_d  = SEED;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= SEED;
      crc_out_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      crc_out_q <= crc_out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign crc_out = crc_out_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_crc_lfsr_serializer.sv
// Directed bench for crc_lfsr_serializer with hand-computed CRC bit streams.
module tb_crc_lfsr_serializer;

  logic clk;
  logic reset_n;
  logic dataIn;
  logic active;
  logic crcOut;
  logic valid;
  logic busy;

  int assertCount = 0;
  int failCount   = 0;

  crc_lfsr_serializer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .data_in (dataIn),
    .active  (active),
    .crc_out (crcOut),
    .valid   (valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic applyStimulus(input logic a, input logic d);
    active = a;
    dataIn = d;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " valid"}, valid, 1'b0);
    checkOutput({tag, " busy"}, busy, 1'b0);
    checkOutput({tag, " crc_out"}, crcOut, 1'b0);
  endtask

  // msg[j] is the j-th message bit; expCrc[i] is the i-th emitted CRC bit.
  task automatic runFrame(input string tag, input int nBits, input logic [7:0] msg,
                          input logic [7:0] expCrc, input bit noisy);
    for (int j = 0; j < nBits; j++) begin
      applyStimulus(1'b1, msg[j]);
      checkOutput($sformatf("%s absorb%0d valid", tag, j), valid, 1'b0);
      checkOutput($sformatf("%s absorb%0d busy", tag, j), busy, 1'b1);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput({tag, " gap valid"}, valid, 1'b0);
    checkOutput({tag, " gap crc_out"}, crcOut, 1'b0);
    checkOutput({tag, " gap busy"}, busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (noisy) begin
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        applyStimulus(1'b0, 1'b0);
      end
      checkOutput($sformatf("%s bit%0d valid", tag, i), valid, 1'b1);
      checkOutput($sformatf("%s bit%0d crc_out", tag, i), crcOut, expCrc[i]);
    end
    active = 1'b0;
    dataIn = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    active  = 1'b0;
    dataIn  = 1'b0;
    #1;
    checkIdle("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] idle with active low");
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 1'b0);
      checkIdle($sformatf("idle%0d", k));
    end

    $display("[TB] single-bit frames");
    runFrame("f0", 1, 8'h00, 8'h6C, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkIdle("after f0");
    runFrame("f1", 1, 8'h01, 8'hA8, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkIdle("after f1");

    $display("[TB] back-to-back frames");
    runFrame("b2b1", 1, 8'h01, 8'hA8, 1'b0);
    runFrame("b2b0", 1, 8'h00, 8'h6C, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkIdle("after b2b");

    $display("[TB] two-bit frames");
    runFrame("m10", 2, 8'h01, 8'h54, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkIdle("after m10");
    runFrame("m01", 2, 8'h02, 8'hF2, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkIdle("after m01");

    $display("[TB] inputs toggled during shift");
    runFrame("noisy0", 1, 8'h00, 8'h6C, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkIdle("after noisy0");

    $display("[TB] reset during shift");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("rst bit%0d valid", i), valid, 1'b1);
    end
    reset_n = 1'b0;
    #1;
    checkIdle("rst async");
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b0);
      checkIdle($sformatf("post-rst%0d", k));
    end
    runFrame("rst f1", 1, 8'h01, 8'hA8, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkIdle("after rst f1");

    $display("[TB] reset during calc");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    checkIdle("calc rst async");
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0);
      checkIdle($sformatf("post-calc-rst%0d", k));
    end
    runFrame("calc rst f0", 1, 8'h00, 8'h6C, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkIdle("after calc rst f0");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
